// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: shared opcodes, per-port FSM states and status-byte layout
//   Used by spi_ram_arbiter and its tests; no ports.
package spi_ram_pkg;

    localparam logic [7:0] OP_WR_MBOX      = 8'h01;
    localparam logic [7:0] OP_RAM          = 8'h03;
    localparam logic [7:0] OP_RD_MBOX_BASE = 8'h80;

    localparam int STAT_RAM_BUSY = 0;
    localparam int STAT_NEW_BASE = 1;

    typedef enum logic [2:0] {
        ST_OPCODE,
        ST_WR_MBOX,
        ST_RD_MBOX,
        ST_RAM,
        ST_IGNORE
    } port_state_t;

endpackage

// File: rtl/spi_ram_arbiter_if.sv
// spi_ram_arbiter_if: host SPI pins and serial-RAM pins of the arbiter
//   host_nss/sck/mosi : per-host SPI inputs (nss active low, CPOL=0)
//   host_miso         : per-host SPI data out
//   ram_nss/sck/mosi  : serial-RAM master outputs
//   ram_miso          : serial-RAM data in
//   ram_owner         : owning host index, MSB set when idle
//   slave modport is the arbiter side, master modport the pin/board side.
interface spi_ram_arbiter_if #(
    parameter int NUM_HOSTS = 2
);
    localparam int OW = $clog2(NUM_HOSTS) + 1;

    logic [NUM_HOSTS-1:0] host_nss;
    logic [NUM_HOSTS-1:0] host_sck;
    logic [NUM_HOSTS-1:0] host_mosi;
    logic [NUM_HOSTS-1:0] host_miso;
    logic                 ram_nss;
    logic                 ram_sck;
    logic                 ram_mosi;
    logic                 ram_miso;
    logic [OW-1:0]        ram_owner;

    modport slave (
        input  host_nss, host_sck, host_mosi, ram_miso,
        output host_miso, ram_nss, ram_sck, ram_mosi, ram_owner
    );

    modport master (
        output host_nss, host_sck, host_mosi, ram_miso,
        input  host_miso, ram_nss, ram_sck, ram_mosi, ram_owner
    );
endinterface

// File: rtl/spi_slave_port.sv
// spi_slave_port: oversampled SPI slave front end for one host
//   clk, reset_n      : system clock, synchronous active-low reset
//   nss_i/sck_i/mosi_i: raw host pins
//   nss_o/sck_o/mosi_o: synchronised copies of the pins
//   data_o            : LSB-first receive shift register
//   cnt_o             : bit index within the current byte
//   done_o            : one-clk strobe on the sck fall that ends the last bit
module spi_slave_port #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          nss_i,
    input  logic                          sck_i,
    input  logic                          mosi_i,
    output logic                          nss_o,
    output logic                          sck_o,
    output logic                          mosi_o,
    output logic [DATA_WIDTH-1:0]         data_o,
    output logic [$clog2(DATA_WIDTH)-1:0] cnt_o,
    output logic                          done_o
);
    localparam int CW = $clog2(DATA_WIDTH);

    logic [2:0]            sync_q [SYNC_STAGES];
    logic                  sck_prev_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [CW-1:0]         cnt_q;
    logic                  rise;
    logic                  fall;

    // Synchronisers are left out of reset so the real nss level is known
    // the moment reset releases.
    always_ff @(posedge clk) begin
        sync_q[0] <= {nss_i, sck_i, mosi_i};
        for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        sck_prev_q <= sync_q[SYNC_STAGES-1][1];
    end

    assign {nss_o, sck_o, mosi_o} = sync_q[SYNC_STAGES-1];
    assign rise   = sck_o & ~sck_prev_q & ~nss_o;
    assign fall   = ~sck_o & sck_prev_q & ~nss_o;
    assign done_o = fall && (cnt_q == CW'(DATA_WIDTH - 1));
    assign data_o = data_q;
    assign cnt_o  = cnt_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (nss_o) cnt_q <= '0;
            else if (fall) cnt_q <= done_o ? '0 : cnt_q + 1'b1;
            if (rise) data_q <= {mosi_o, data_q[DATA_WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter: multi-host SPI slave with mailboxes and a round-robin
// shared serial-RAM master port
//   clk, reset_n : system clock, synchronous active-low reset
//   bus_if       : host SPI pins, serial-RAM pins and ram_owner (slave modport)
module spi_ram_arbiter
    import spi_ram_pkg::*;
#(
    parameter int NUM_HOSTS   = 2,
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    spi_ram_arbiter_if.slave      bus_if
);
    localparam int N  = NUM_HOSTS;
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam int OW = $clog2(N) + 1;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   nss_s, sck_s, mosi_s, done;
    logic [W-1:0]   data [N];
    logic [CW-1:0]  cnt [N];

    port_state_t    state_q [N];
    port_state_t    state_d [N];
    logic [W-1:0]   tx_q [N];
    logic [W-1:0]   mbox_q [N];
    logic [N-1:0]   new_q;
    logic           owned_q;
    logic [IW-1:0]  own_q;
    logic [IW-1:0]  rr_q;
    logic           ram_nss_q, ram_sck_q, ram_mosi_q;

    logic [N-1:0]   req;
    logic [2*N-1:0] rot;
    logic           win_v;
    logic [IW-1:0]  win;
    logic [W-1:0]   status [N];
    logic [N-1:0]   miso;

    for (genvar g = 0; g < N; g++) begin : g_port
        spi_slave_port #(
            .DATA_WIDTH  (W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_port (
            .clk     (clk),
            .reset_n (reset_n),
            .nss_i   (bus_if.host_nss[g]),
            .sck_i   (bus_if.host_sck[g]),
            .mosi_i  (bus_if.host_mosi[g]),
            .nss_o   (nss_s[g]),
            .sck_o   (sck_s[g]),
            .mosi_o  (mosi_s[g]),
            .data_o  (data[g]),
            .cnt_o   (cnt[g]),
            .done_o  (done[g])
        );
    end

    always_comb begin
        for (int h = 0; h < N; h++)
            req[h] = done[h] && state_q[h] == ST_OPCODE && data[h][7:0] == OP_RAM && !owned_q;
    end

    // Rotate requests so bit 0 is rr_q; the first set bit is the winner.
    always_comb begin
        rot   = {req, req} >> rr_q;
        win_v = 1'b0;
        win   = '0;
        for (int i = 0; i < N; i++) begin
            if (!win_v && rot[i]) begin
                win_v = 1'b1;
                win   = IW'((int'(rr_q) + i >= N) ? int'(rr_q) + i - N : int'(rr_q) + i);
            end
        end
    end

    // A port that sees nss low as reset releases waits out that frame.
    always_ff @(posedge clk) begin
        for (int h = 0; h < N; h++)
            state_q[h] <= !reset_n ? (nss_s[h] ? ST_OPCODE : ST_IGNORE) : state_d[h];
    end

    always_comb begin
        for (int h = 0; h < N; h++) begin
            state_d[h] = state_q[h];
            if (nss_s[h])
                state_d[h] = ST_OPCODE;
            else if (done[h] && state_q[h] == ST_OPCODE)
                state_d[h] = (data[h][7:0] == OP_WR_MBOX)                      ? ST_WR_MBOX :
                             ((data[h][7:0] & OP_RD_MBOX_BASE) != 8'h00)       ? ST_RD_MBOX :
                             (data[h][7:0] == OP_RAM && win_v && win == IW'(h)) ? ST_RAM :
                                                                                  ST_IGNORE;
        end
    end

    always_comb begin
        for (int h = 0; h < N; h++) begin
            status[h] = '0;
            status[h][STAT_RAM_BUSY] = owned_q && own_q != IW'(h);
            for (int k = 0; k < N; k++) status[h][STAT_NEW_BASE+k] = new_q[k];
            miso[h] = (owned_q && own_q == IW'(h))                 ? bus_if.ram_miso :
                      (nss_s[h] || state_q[h] == ST_IGNORE)        ? 1'b0 :
                                                                     tx_q[h][cnt[h]];
        end
    end

    // Reads are handled before writes so a same-clk write keeps new set,
    // while the reader still captures the pre-write mailbox value.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int h = 0; h < N; h++) begin
                tx_q[h]   <= '0;
                mbox_q[h] <= '0;
            end
            new_q <= '0;
        end else begin
            for (int h = 0; h < N; h++) begin
                if (nss_s[h])
                    tx_q[h] <= status[h];
                else if (done[h] && state_q[h] == ST_OPCODE && (data[h][7:0] & OP_RD_MBOX_BASE) != 8'h00) begin
                    tx_q[h] <= '0;
                    for (int k = 0; k < N; k++) begin
                        if (data[h][6:0] == 7'(k)) begin
                            tx_q[h]  <= mbox_q[k];
                            new_q[k] <= 1'b0;
                        end
                    end
                end
            end
            for (int h = 0; h < N; h++) begin
                if (done[h] && state_q[h] == ST_WR_MBOX) begin
                    mbox_q[h] <= data[h];
                    new_q[h]  <= 1'b1;
                end
            end
        end
    end

    // ram_sck stays low in the grant cycle so the RAM never sees opcode edges.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            owned_q    <= 1'b0;
            own_q      <= '0;
            rr_q       <= '0;
            ram_nss_q  <= 1'b1;
            ram_sck_q  <= 1'b0;
            ram_mosi_q <= 1'b0;
        end else if (!owned_q) begin
            if (win_v) begin
                owned_q   <= 1'b1;
                own_q     <= win;
                ram_nss_q <= 1'b0;
            end
            ram_sck_q  <= 1'b0;
            ram_mosi_q <= 1'b0;
        end else if (nss_s[own_q]) begin
            owned_q    <= 1'b0;
            ram_nss_q  <= 1'b1;
            ram_sck_q  <= 1'b0;
            ram_mosi_q <= 1'b0;
            rr_q       <= (own_q == IW'(N - 1)) ? '0 : own_q + 1'b1;
        end else begin
            ram_sck_q  <= sck_s[own_q];
            ram_mosi_q <= mosi_s[own_q];
        end
    end

    assign bus_if.host_miso = miso;
    assign bus_if.ram_nss   = ram_nss_q;
    assign bus_if.ram_sck   = ram_sck_q;
    assign bus_if.ram_mosi  = ram_mosi_q;
    assign bus_if.ram_owner = owned_q ? OW'(own_q) : OW'(1) << (OW - 1);
endmodule

// File: doc/spi_ram_arbiter.md
Name: spi_ram_arbiter

Overview:
Synchronous, parametrised successor to the CPLD SPI glue. It provides NUM_HOSTS oversampled SPI slave ports; each port runs its own opcode state machine. Hosts share one serial-RAM master port through round-robin arbitration rather than a fixed bus mode, and exchange bytes through per-host mailboxes. It sits between the MCU/coprocessor SPI pins and the serial RAM; device/flash chip-select decoding stays outside.

Parameters:
NUM_HOSTS, 2, number of SPI slave ports (1..7)
DATA_WIDTH, 8, SPI byte width in bits
SYNC_STAGES, 2, synchroniser flops on each host input

Ports:
clk  input  1  system clock
reset_n  input  1  synchronous active-low reset
host_nss  input  NUM_HOSTS  per-host chip select, active low
host_sck  input  NUM_HOSTS  per-host SPI clock, CPOL=0
host_mosi  input  NUM_HOSTS  per-host data in
host_miso  output  NUM_HOSTS  per-host data out
ram_nss  output  1  serial RAM chip select, active low
ram_sck  output  1  serial RAM clock
ram_mosi  output  1  serial RAM data out
ram_miso  input  1  serial RAM data in
ram_owner  output  $clog2(NUM_HOSTS)+1  owning host index; MSB=1 means idle

Behaviour:
- Clock and reset: one clock, clk. reset_n is synchronous and active-low.
- Reset state: ram_nss=1, ram_sck=0, ram_mosi=0, host_miso=0, ram_owner=idle. Mailboxes, new-flags and the round-robin pointer clear to 0.
- Post-reset entry rule: a port whose synced nss is low at reset release enters IGNORE and stays there until nss rises.
- Input path: each host input passes through SYNC_STAGES flops. A rise/fall of synced sck is detected with one extra flop.
- Host timing: each sck half-period must be ≥ SYNC_STAGES+3 clk.
- Per-port shifting:
  - MOSI is sampled on a detected sck rise, shifting LSB-first: data <= {mosi, data[W-1:1]}.
  - MISO updates on a detected sck fall, presenting bit[cnt] of the tx byte.
  - The bit counter (clog2(W) bits) wraps at W.
- Byte completion: fires on the detected fall ending bit W-1.
- Synced nss high: counter=0, state=OPCODE, host_miso=0, tx=status byte.
- Status byte, shifted out during the opcode byte:
  - bit0 = RAM owned by another host.
  - bit k+1 = mailbox_new[k].
  - Unused bits = 0.
- States: OPCODE, WR_MBOX, RD_MBOX, RAM, IGNORE.
- Transitions on opcode byte completion:
  - 0x01 -> WR_MBOX.
  - 0x80|k -> RD_MBOX. tx is loaded at that cycle with mailbox[k], or 0 if k≥NUM_HOSTS. mailbox_new[k] clears.
  - 0x03 -> RAM if granted, else IGNORE.
  - Any other value -> IGNORE.
- WR_MBOX: every completed byte overwrites the host's own mailbox and sets mailbox_new[self].
- RD_MBOX: repeats the same captured byte for every following byte.
- IGNORE: MISO=0 until nss rises.
- Arbitration:
  - A request is a 0x03 completion while ram_owner is idle.
  - If several requests arrive in the same clk, the winner is the first index ≥ rr_ptr (wrapping). Losers go to IGNORE.
  - The grant registers one clk after completion.
- RAM pass-through while granted:
  - ram_nss=0, ram_sck=owner synced sck, ram_mosi=owner synced mosi.
  - host_miso[owner]=ram_miso (combinational mux).
  - ram_sck is 0 in the grant cycle. It then follows synced sck, so the RAM never sees opcode-byte edges.
- Release: the owner's synced nss rise sets ram_nss=1 and ram_sck=0 on the next clk, ram_owner=idle, rr_ptr=owner+1 mod NUM_HOSTS.
- A request completing in the release cycle sees the RAM as busy and is denied.
- Mailbox conflicts: a read and a write of the same mailbox in the same clk return the old value. The write lands and new stays set.
- Reset asserted mid-RAM-transfer: ram_nss=1 on the next clk.

Decomposition:
- Package spi_ram_pkg: opcode constants (OP_WR_MBOX=0x01, OP_RAM=0x03, OP_RD_MBOX_BASE=0x80), port_state_t enum, status-bit positions.
- Sub-module spi_slave_port, instantiated NUM_HOSTS times: synchroniser, edge detect, shift register, bit counter, byte-done strobe.
- The top level holds the opcode FSMs, mailboxes, arbiter and RAM mux.

Test Plan:
- Host0 sends 0x01,0xA5; host1 sends 0x80 then 1 byte -> host1 reads status 0x02 during the opcode byte, then 0xA5; mailbox_new[0] then clears.
- Host0 sends 0x03 followed by 0x03,0x00,0x10 -> the RAM sees exactly those 3 bytes with nss low; host0 MISO mirrors ram_miso; ram_owner=0; release on nss rise.
- Host0 holds the RAM; host1 sends 0x03 -> host1 status bit0=1, host1 goes to IGNORE with MISO 0, the RAM is undisturbed.
- Both hosts complete 0x03 in the same clk with rr_ptr=0 -> host0 wins. Repeat after release -> host1 wins.
- reset_n low mid-RAM-transfer -> ram_nss=1 on the next clk. Host nss still low -> IGNORE; after nss toggles, a new 0x03 is granted normally.
- Opcode 0x7E, then 0x85 with NUM_HOSTS=2 -> both give MISO 0x00 for all following bytes; no state change.
